// File: rtl/ex_div.sv
// ex_div: iterative radix-2 restoring divider for the EX stage.
// One quotient bit per cycle, signed or unsigned, with divide-by-zero and
// annul (flush) handling. Returns {remainder, quotient} for HI/LO writeback.
//
// Handshake: EX raises start_i with the operands and holds it until it sees
// ready_o. ready_o/result_o are valid together for as long as start_i stays
// high in END. Dropping start_i (or raising annul_i) returns to FREE.
// annul_i always wins over start_i.
module ex_div #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 signed_div_i,
  input  logic [WIDTH-1:0]     opdata1_i,
  input  logic [WIDTH-1:0]     opdata2_i,
  input  logic                 start_i,
  input  logic                 annul_i,
  output logic [2*WIDTH-1:0]   result_o,
  output logic                 ready_o,
  output logic                 stallreq_o,
  output logic [1:0]           state_o
);

  typedef enum logic [1:0] {
    FREE    = 2'd0,
    BY_ZERO = 2'd1,
    ON      = 2'd2,
    END     = 2'd3
  } state_t;

  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
  localparam logic [WIDTH-1:0] ALL_ONES = '1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   dvd;   // dividend shifting out, quotient shifting in
  logic [WIDTH-1:0]   dvs;   // latched (absolute) divisor
  logic [WIDTH-1:0]   rem;   // running partial remainder
  logic               dvd_neg;
  logic               dvs_neg;

  logic [WIDTH-1:0]   op1_abs;
  logic [WIDTH-1:0]   op2_abs;
  logic [WIDTH:0]     shifted;
  logic [WIDTH+1:0]   diff;
  logic               borrow;
  logic [WIDTH-1:0]   rem_nxt;
  logic [WIDTH-1:0]   quo_nxt;
  logic [WIDTH-1:0]   q_fix;
  logic [WIDTH-1:0]   r_fix;

  assign state_o    = state;
  assign stallreq_o = start_i & ~ready_o & ~annul_i;

  // Operand magnitudes and one restoring step with the final sign fix.
  // The shifted remainder keeps its top bit so unsigned divisors with the
  // MSB set still divide correctly; the subtract is widened to see the borrow.
  always_comb begin
    op1_abs = (signed_div_i && opdata1_i[WIDTH-1]) ? (~opdata1_i + ONE) : opdata1_i;
    op2_abs = (signed_div_i && opdata2_i[WIDTH-1]) ? (~opdata2_i + ONE) : opdata2_i;
    shifted = {rem, dvd[WIDTH-1]};
    diff    = {1'b0, shifted} - {2'b00, dvs};
    borrow  = diff[WIDTH+1];
    rem_nxt = borrow ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
    quo_nxt = {dvd[WIDTH-2:0], ~borrow};
    q_fix   = (dvd_neg ^ dvs_neg) ? (~quo_nxt + ONE) : quo_nxt;
    r_fix   = dvd_neg ? (~rem_nxt + ONE) : rem_nxt;
  end

  // Divider FSM: latch operands, iterate WIDTH steps, hold result until released.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= FREE;
      cnt      <= '0;
      result_o <= '0;
      ready_o  <= 1'b0;
      dvd      <= '0;
      dvs      <= '0;
      rem      <= '0;
      dvd_neg  <= 1'b0;
      dvs_neg  <= 1'b0;
    end else begin
      case (state)
        FREE: begin
          if (start_i && !annul_i) begin
            dvd_neg <= signed_div_i & opdata1_i[WIDTH-1];
            dvs_neg <= signed_div_i & opdata2_i[WIDTH-1];
            dvs     <= op2_abs;
            rem     <= '0;
            cnt     <= '0;
            if (opdata2_i == '0) begin
              // Keep the raw dividend: it is returned unchanged as remainder.
              dvd   <= opdata1_i;
              state <= BY_ZERO;
            end else begin
              dvd   <= op1_abs;
              state <= ON;
            end
          end
        end
        BY_ZERO: begin
          result_o <= {dvd, ALL_ONES};
          ready_o  <= 1'b1;
          state    <= END;
        end
        ON: begin
          if (annul_i) begin
            result_o <= '0;
            ready_o  <= 1'b0;
            state    <= FREE;
          end else begin
            dvd <= quo_nxt;
            rem <= rem_nxt;
            cnt <= cnt + CNT_W'(1);
            if (cnt == LAST_CNT) begin
              result_o <= {r_fix, q_fix};
              ready_o  <= 1'b1;
              state    <= END;
            end
          end
        end
        END: begin
          if (!start_i || annul_i) begin
            result_o <= '0;
            ready_o  <= 1'b0;
            state    <= FREE;
          end
        end
        default: state <= FREE;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_div.sv
// tb_ex_div: directed-vector bench for ex_div with hand-computed results.
module tb_ex_div;

  logic        clk;
  logic        rst;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        start_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;
  logic        stallreq_o;
  logic [1:0]  state_o;

  int total = 0;
  int bad   = 0;
  logic [63:0] exp_q[$];

  localparam logic [1:0] ST_FREE = 2'd0;
  localparam logic [1:0] ST_ON   = 2'd2;

  ex_div #(.WIDTH(32), .CNT_W(6)) dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o),
    .stallreq_o   (stallreq_o),
    .state_o      (state_o)
  );

  // Clock generation.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Run one division; expected result is popped from exp_q.
  task automatic do_div(input string tag, input logic sg, input logic [31:0] a,
                        input logic [31:0] b, input int exp_lat, input int hold);
    int n;
    int stall_bad;
    logic [63:0] exp_r;
    logic [63:0] held;
    exp_r = exp_q.pop_front();
    signed_div_i = sg;
    opdata1_i    = a;
    opdata2_i    = b;
    start_i      = 1'b1;
    #1;
    chk({tag, "_stall_start"}, 64'(stallreq_o), 64'd1);
    n = 0;
    stall_bad = 0;
    while (!ready_o && n < 100) begin
      tick();
      n++;
      // Operands change mid-flight; the latched copy must be used.
      opdata1_i = $urandom_range(32'hFFFF_FFFF, 0);
      opdata2_i = $urandom_range(32'hFFFF_FFFF, 0);
      if (!ready_o && !stallreq_o) stall_bad++;
    end
    chk({tag, "_latency"}, 64'(n), 64'(exp_lat));
    chk({tag, "_result"}, result_o, exp_r);
    chk({tag, "_stall_drop"}, 64'(stallreq_o), 64'd0);
    chk({tag, "_stall_busy"}, 64'(stall_bad), 64'd0);
    held = result_o;
    for (int i = 0; i < hold; i++) begin
      tick();
      chk({tag, "_hold_ready"}, 64'(ready_o), 64'd1);
      chk({tag, "_hold_result"}, result_o, held);
    end
    start_i = 1'b0;
    tick();
    chk({tag, "_rel_ready"}, 64'(ready_o), 64'd0);
    chk({tag, "_rel_result"}, result_o, 64'd0);
    chk({tag, "_rel_state"}, 64'(state_o), 64'(ST_FREE));
  endtask

  initial begin
    int seen_ready;
    rst = 1'b0;
    signed_div_i = 1'b0;
    opdata1_i = '0;
    opdata2_i = '0;
    start_i = 1'b0;
    annul_i = 1'b0;
    tick();
    tick();
    chk("reset_ready", 64'(ready_o), 64'd0);
    chk("reset_result", result_o, 64'd0);
    chk("reset_state", 64'(state_o), 64'(ST_FREE));
    chk("reset_stall", 64'(stallreq_o), 64'd0);
    rst = 1'b1;
    tick();
    chk("idle_stall", 64'(stallreq_o), 64'd0);

    // Directed vectors.
    exp_q.push_back({32'd2, 32'd14});
    do_div("u100_7", 1'b0, 32'd100, 32'd7, 33, 0);
    exp_q.push_back({32'hFFFF_FFFF, 32'hFFFF_FFFD});
    do_div("s_m7_2", 1'b1, 32'hFFFF_FFF9, 32'h0000_0002, 33, 0);
    exp_q.push_back({32'h0000_0001, 32'hFFFF_FFFD});
    do_div("s_7_m2", 1'b1, 32'h0000_0007, 32'hFFFF_FFFE, 33, 0);
    exp_q.push_back({32'h1234_5678, 32'hFFFF_FFFF});
    do_div("u_div0", 1'b0, 32'h1234_5678, 32'h0, 2, 0);
    exp_q.push_back({32'h8000_0001, 32'hFFFF_FFFF});
    do_div("s_div0", 1'b1, 32'h8000_0001, 32'h0, 2, 0);
    exp_q.push_back({32'h0, 32'h8000_0000});
    do_div("s_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 33, 0);
    exp_q.push_back({32'h0, 32'hFFFF_FFFF});
    do_div("u_max_1", 1'b0, 32'hFFFF_FFFF, 32'h1, 33, 0);
    exp_q.push_back({32'h1, 32'h1});
    do_div("u_max_big", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, 0);

    // Annul at ON cycle 10.
    signed_div_i = 1'b0;
    opdata1_i = 32'd1000;
    opdata2_i = 32'd3;
    start_i = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    chk("annul_pre_state", 64'(state_o), 64'(ST_ON));
    annul_i = 1'b1;
    #1;
    chk("annul_stall", 64'(stallreq_o), 64'd0);
    tick();
    chk("annul_state", 64'(state_o), 64'(ST_FREE));
    chk("annul_result", result_o, 64'd0);
    annul_i = 1'b0;
    start_i = 1'b0;
    seen_ready = 0;
    for (int i = 0; i < 40; i++) begin
      if (ready_o) seen_ready++;
      tick();
    end
    chk("annul_no_ready", 64'(seen_ready), 64'd0);
    exp_q.push_back({32'd0, 32'd3});
    do_div("u9_3", 1'b0, 32'd9, 32'd3, 33, 0);

    // Reset at ON cycle 20.
    opdata1_i = 32'd500;
    opdata2_i = 32'd9;
    start_i = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    chk("rst_pre_state", 64'(state_o), 64'(ST_ON));
    rst = 1'b0;
    tick();
    chk("rst_state", 64'(state_o), 64'(ST_FREE));
    chk("rst_ready", 64'(ready_o), 64'd0);
    chk("rst_result", result_o, 64'd0);
    rst = 1'b1;
    start_i = 1'b0;
    tick();

    // Result held while start stays high in END.
    exp_q.push_back({32'hFFFF_FFFE, 32'hFFFF_FFF2});
    do_div("s_m100_7_hold", 1'b1, 32'hFFFF_FF9C, 32'd7, 33, 3);

    chk("exp_q_empty", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
